// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush and
// optional two-entry skid buffer for registered back-pressure.
module pipe_stage_reg #(
    parameter int PC_W = 32,
    parameter int INST_W = 32,
    parameter int PAYLOAD_W = 128,
    parameter int SKID = 0,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h00000013)
) (
    input  logic                 i_Clk,
    input  logic                 i_reset_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [PC_W-1:0]      i_pc,
    input  logic [INST_W-1:0]    i_inst,
    input  logic [PAYLOAD_W-1:0] i_payload,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [PC_W-1:0]      o_pc,
    output logic [INST_W-1:0]    o_inst,
    output logic [PAYLOAD_W-1:0] o_payload,
    output logic [1:0]           o_count
);

    logic                 skid_v;
    logic [PC_W-1:0]      skid_pc;
    logic [INST_W-1:0]    skid_inst;
    logic [PAYLOAD_W-1:0] skid_payload;

    logic in_xfer;
    logic out_xfer;
    logic main_ld;
    logic main_pop;
    logic main_clr;
    logic skid_ld;

    // With the skid buffer, ready is a pure flop output: free unless full.
    generate
        if (SKID != 0) begin : g_skid
            assign o_ready = !skid_v;
        end else begin : g_noskid
            assign o_ready = !o_valid | i_ready;
        end
    endgenerate

    assign in_xfer  = i_valid & o_ready;
    assign out_xfer = o_valid & i_ready;
    assign o_count  = {skid_v, o_valid & !skid_v};

    always_comb begin
        main_ld  = 1'b0;
        main_pop = 1'b0;
        main_clr = 1'b0;
        skid_ld  = 1'b0;
        if (SKID == 0) begin
            if (in_xfer) main_ld = 1'b1;
            else if (out_xfer) main_clr = 1'b1;
        end else if (skid_v) begin
            if (out_xfer) main_pop = 1'b1;
        end else if (in_xfer && o_valid && !out_xfer) begin
            skid_ld = 1'b1;
        end else if (in_xfer) begin
            main_ld = 1'b1;
        end else if (out_xfer) begin
            main_clr = 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid      <= 1'b0;
            o_pc         <= '0;
            o_inst       <= NOP_INST;
            o_payload    <= '0;
            skid_v       <= 1'b0;
            skid_pc      <= '0;
            skid_inst    <= NOP_INST;
            skid_payload <= '0;
        end else if (i_flush) begin
            o_valid      <= 1'b0;
            o_pc         <= '0;
            o_inst       <= NOP_INST;
            o_payload    <= '0;
            skid_v       <= 1'b0;
            skid_pc      <= '0;
            skid_inst    <= NOP_INST;
            skid_payload <= '0;
        end else begin
            if (main_ld) begin
                o_valid   <= 1'b1;
                o_pc      <= i_pc;
                o_inst    <= i_inst;
                o_payload <= i_payload;
            end else if (main_pop) begin
                o_pc      <= skid_pc;
                o_inst    <= skid_inst;
                o_payload <= skid_payload;
            end else if (main_clr) begin
                o_valid   <= 1'b0;
                o_pc      <= '0;
                o_inst    <= NOP_INST;
                o_payload <= '0;
            end
            if (skid_ld) begin
                skid_v       <= 1'b1;
                skid_pc      <= i_pc;
                skid_inst    <= i_inst;
                skid_payload <= i_payload;
            end else if (main_pop) begin
                skid_v       <= 1'b0;
                skid_pc      <= '0;
                skid_inst    <= NOP_INST;
                skid_payload <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench driving SKID=0 and SKID=1 instances with shared stimulus
// and checking each against a FIFO-of-held-entries reference.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [31:0]  pc;
        logic [31:0]  inst;
        logic [127:0] pl;
    } ent_t;

    localparam logic [31:0] NOP = 32'h00000013;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b0;
    logic         i_flush = 1'b0;
    logic [31:0]  i_pc = '0;
    logic [31:0]  i_inst = '0;
    logic [127:0] i_payload = '0;

    logic         v0, r0, v1, r1;
    logic [31:0]  pc0, pc1, in0, in1;
    logic [127:0] pl0, pl1;
    logic [1:0]   c0, c1;

    ent_t q0[$];
    ent_t q1[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.SKID(0)) u0 (
        .i_Clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(r0),
        .i_pc(i_pc), .i_inst(i_inst), .i_payload(i_payload), .i_flush(i_flush),
        .o_valid(v0), .i_ready(i_ready), .o_pc(pc0), .o_inst(in0),
        .o_payload(pl0), .o_count(c0)
    );

    pipe_stage_reg #(.SKID(1)) u1 (
        .i_Clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(r1),
        .i_pc(i_pc), .i_inst(i_inst), .i_payload(i_payload), .i_flush(i_flush),
        .o_valid(v1), .i_ready(i_ready), .o_pc(pc1), .o_inst(in1),
        .o_payload(pl1), .o_count(c1)
    );

    task automatic chk(input string nm, input int id,
                       input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d got %0h want %0h", nm, id, got, want);
        end
    endtask

    task automatic mon(input int id, input logic v, input logic rdy,
                       input logic [31:0] pc, input logic [31:0] inst,
                       input logic [127:0] pl, input logic [1:0] cnt);
        ent_t e;
        int sz;
        sz = (id == 0) ? q0.size() : q1.size();
        chk("count", id, 128'(cnt), 128'(sz));
        if (id == 0) chk("ready", id, 128'(rdy), 128'(sz == 0 || i_ready));
        else chk("ready", id, 128'(rdy), 128'(sz < 2));
        chk("valid", id, 128'(v), 128'(sz != 0));
        if (sz == 0) begin
            chk("idle_pc", id, 128'(pc), 128'(0));
            chk("idle_inst", id, 128'(inst), 128'(NOP));
            chk("idle_payload", id, pl, 128'(0));
        end else begin
            e = (id == 0) ? q0[0] : q1[0];
            chk("pc", id, 128'(pc), 128'(e.pc));
            chk("inst", id, 128'(inst), 128'(e.inst));
            chk("payload", id, pl, e.pl);
            if (i_ready) begin
                if (id == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
            end
        end
    endtask

    // Out-transfers are decided by values stable at the falling edge.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            mon(0, v0, r0, pc0, in0, pl0, c0);
            mon(1, v1, r1, pc1, in1, pl1, c1);
        end
    end

    task automatic step(input bit v, input bit r, input bit f,
                        input logic [31:0] pc);
        bit a0, a1;
        ent_t e;
        i_valid   = v;
        i_ready   = r;
        i_flush   = f;
        i_pc      = pc;
        i_inst    = $urandom;
        i_payload = {$urandom, $urandom, $urandom, $urandom};
        e.pc   = pc;
        e.inst = i_inst;
        e.pl   = i_payload;
        @(negedge clk);
        a0 = v && r0;
        a1 = v && r1;
        @(posedge clk);
        if (f) begin
            q0.delete();
            q1.delete();
        end else begin
            if (a0) q0.push_back(e);
            if (a1) q1.push_back(e);
        end
        #1;
    endtask

    task automatic chk_cleared(input string nm);
        chk({nm, "_valid"}, 0, 128'(v0), 128'(0));
        chk({nm, "_valid"}, 1, 128'(v1), 128'(0));
        chk({nm, "_inst"}, 0, 128'(in0), 128'(NOP));
        chk({nm, "_inst"}, 1, 128'(in1), 128'(NOP));
        chk({nm, "_pc"}, 0, 128'(pc0), 128'(0));
        chk({nm, "_pc"}, 1, 128'(pc1), 128'(0));
        chk({nm, "_payload"}, 0, pl0, 128'(0));
        chk({nm, "_payload"}, 1, pl1, 128'(0));
        chk({nm, "_count"}, 0, 128'(c0), 128'(0));
        chk({nm, "_count"}, 1, 128'(c1), 128'(0));
        chk({nm, "_ready"}, 0, 128'(r0), 128'(1));
        chk({nm, "_ready"}, 1, 128'(r1), 128'(1));
    endtask

    initial begin
        repeat (3) begin
            @(posedge clk);
            #1;
            i_valid   = 1'b1;
            i_ready   = 1'($urandom);
            i_flush   = 1'($urandom);
            i_pc      = $urandom;
            i_inst    = $urandom;
            i_payload = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        chk_cleared("reset");
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        step(1, 1, 0, 32'h100);
        step(1, 1, 0, 32'h104);
        step(1, 1, 0, 32'h108);
        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);

        step(1, 0, 0, 32'h100);
        step(1, 0, 0, 32'h104);
        step(1, 0, 0, 32'h108);
        step(1, 0, 0, 32'h10c);
        step(1, 1, 0, 32'h110);
        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);

        step(1, 0, 0, 32'h200);
        step(1, 0, 0, 32'h204);
        step(1, 0, 1, 32'h208);
        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);

        step(1, 0, 0, 32'h300);
        step(1, 0, 0, 32'h304);
        step(1, 1, 1, 32'h308);
        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);

        repeat (1500) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0, $urandom);
        end

        step(1, 0, 0, 32'h400);
        step(1, 0, 0, 32'h404);
        #2;
        rst_n = 1'b0;
        #1;
        chk_cleared("midreset");
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 1, 0, 32'h500);
        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
